// File: rtl/rf_req_fifo_if.sv
// rf_req_fifo_if
//   Bundles the request-queue traffic between the register-allocation stage,
//   the request FIFO and the banked register file.
//   master : the side that pushes requests and observes the read stream (RAU/bench)
//   slave  : the request FIFO itself
// Signals
//   Valid_RAU_ReqFIFO / Ready_ReqFIFO_RAU : push handshake
//   Src{1,2}_Valid/Phy_Bank_ID/Phy_Row_ID : per-source operand address
//   OCID_RAU_OC                            : one-hot target operand collector
//   BankBusy_RF_ReqFIFO                    : per-bank read-port blocked this cycle
//   RdEn/RdRow/RdOCID/RdSlot_ReqFIFO_RF    : registered per-bank read request
//   Count / Empty                          : queue occupancy
interface rf_req_fifo_if #(
  parameter int AW = 2
);
  logic          Valid_RAU_ReqFIFO;
  logic          Ready_ReqFIFO_RAU;
  logic          Src1_Valid;
  logic [1:0]    Src1_Phy_Bank_ID;
  logic [2:0]    Src1_Phy_Row_ID;
  logic          Src2_Valid;
  logic [1:0]    Src2_Phy_Bank_ID;
  logic [2:0]    Src2_Phy_Row_ID;
  logic [3:0]    OCID_RAU_OC;
  logic [3:0]    BankBusy_RF_ReqFIFO;
  logic [3:0]    RdEn_ReqFIFO_RF;
  logic [11:0]   RdRow_ReqFIFO_RF;
  logic [7:0]    RdOCID_ReqFIFO_RF;
  logic [3:0]    RdSlot_ReqFIFO_RF;
  logic [AW:0]   Count;
  logic          Empty;

  modport master (
    output Valid_RAU_ReqFIFO, Src1_Valid, Src1_Phy_Bank_ID, Src1_Phy_Row_ID,
           Src2_Valid, Src2_Phy_Bank_ID, Src2_Phy_Row_ID, OCID_RAU_OC,
           BankBusy_RF_ReqFIFO,
    input  Ready_ReqFIFO_RAU, RdEn_ReqFIFO_RF, RdRow_ReqFIFO_RF,
           RdOCID_ReqFIFO_RF, RdSlot_ReqFIFO_RF, Count, Empty
  );

  modport slave (
    input  Valid_RAU_ReqFIFO, Src1_Valid, Src1_Phy_Bank_ID, Src1_Phy_Row_ID,
           Src2_Valid, Src2_Phy_Bank_ID, Src2_Phy_Row_ID, OCID_RAU_OC,
           BankBusy_RF_ReqFIFO,
    output Ready_ReqFIFO_RAU, RdEn_ReqFIFO_RF, RdRow_ReqFIFO_RF,
           RdOCID_ReqFIFO_RF, RdSlot_ReqFIFO_RF, Count, Empty
  );
endinterface

// File: rtl/rf_req_fifo.sv
// rf_req_fifo
//   In-order queue of per-instruction operand read requests feeding four
//   single-read-port register-file banks. Only the head entry issues; its two
//   sources are read in the same cycle when their banks differ and are free,
//   otherwise the reads are split over several cycles (src1 wins a conflict).
// Ports
//   clk : clock, all state on rising edge
//   rst : synchronous, active-high reset
//   bus : rf_req_fifo_if.slave (push handshake, bank busy, read request, occupancy)
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_IDLE  | queue empty, no head to evaluate
// ST_ISSUE | head entry valid, issuing its pending operand reads
module rf_req_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic         clk,
  input  logic         rst,
  rf_req_fifo_if.slave bus
);

  typedef enum logic {ST_IDLE, ST_ISSUE} state_e;

  localparam logic [AW:0] FULL = DEPTH[AW:0];

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  logic [1:0]    bank1_q [DEPTH];
  logic [2:0]    row1_q  [DEPTH];
  logic [1:0]    bank2_q [DEPTH];
  logic [2:0]    row2_q  [DEPTH];
  logic [1:0]    ocid_q  [DEPTH];
  logic          pend1_q [DEPTH];
  logic          pend2_q [DEPTH];

  logic [3:0]    rd_en_q,   rd_en_d;
  logic [11:0]   rd_row_q,  rd_row_d;
  logic [7:0]    rd_ocid_q, rd_ocid_d;
  logic [3:0]    rd_slot_q, rd_slot_d;

  logic          push, pop, head_vld;
  logic          iss1, iss2;
  logic          h_p1, h_p2;
  logic [1:0]    h_b1, h_b2, h_oc;
  logic [2:0]    h_r1, h_r2;
  logic [1:0]    push_oc;

  // Zero or multi-hot collector IDs fall back to collector 0.
  always_comb begin
    push_oc = 2'd0;
    case (bus.OCID_RAU_OC)
      4'b0001: push_oc = 2'd0;
      4'b0010: push_oc = 2'd1;
      4'b0100: push_oc = 2'd2;
      4'b1000: push_oc = 2'd3;
      default: push_oc = 2'd0;
    endcase
  end

  // Head evaluation and pointer/count bookkeeping.
  always_comb begin
    head_vld = (state_q == ST_ISSUE);
    h_p1     = pend1_q[rd_ptr_q];
    h_p2     = pend2_q[rd_ptr_q];
    h_b1     = bank1_q[rd_ptr_q];
    h_b2     = bank2_q[rd_ptr_q];
    h_r1     = row1_q[rd_ptr_q];
    h_r2     = row2_q[rd_ptr_q];
    h_oc     = ocid_q[rd_ptr_q];

    iss1 = head_vld & h_p1 & ~bus.BankBusy_RF_ReqFIFO[h_b1];
    iss2 = head_vld & h_p2 & ~bus.BankBusy_RF_ReqFIFO[h_b2]
         & ~(iss1 & (h_b1 == h_b2));
    // Pop once nothing remains pending after this cycle's issue; an entry
    // with no valid sources therefore retires in its first head cycle.
    pop  = head_vld & ~(h_p1 & ~iss1) & ~(h_p2 & ~iss2);
    push = bus.Valid_RAU_ReqFIFO & (count_q < FULL);

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Head FSM: a pushed entry becomes head the cycle after it is written.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (count_d != '0) state_d = ST_ISSUE;
      ST_ISSUE: if (count_d == '0) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Per-bank read request for next cycle; iss1/iss2 never target one bank.
  always_comb begin
    rd_en_d   = '0;
    rd_row_d  = '0;
    rd_ocid_d = '0;
    rd_slot_d = '0;
    for (int b = 0; b < 4; b++) begin
      if (iss1 && (h_b1 == b[1:0])) begin
        rd_en_d[b]          = 1'b1;
        rd_row_d[3*b +: 3]  = h_r1;
        rd_ocid_d[2*b +: 2] = h_oc;
        rd_slot_d[b]        = 1'b0;
      end else if (iss2 && (h_b2 == b[1:0])) begin
        rd_en_d[b]          = 1'b1;
        rd_row_d[3*b +: 3]  = h_r2;
        rd_ocid_d[2*b +: 2] = h_oc;
        rd_slot_d[b]        = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_en_q   <= '0;
      rd_row_q  <= '0;
      rd_ocid_q <= '0;
      rd_slot_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_en_q   <= rd_en_d;
      rd_row_q  <= rd_row_d;
      rd_ocid_q <= rd_ocid_d;
      rd_slot_q <= rd_slot_d;
    end
  end

  // Entry storage. The head slot and the write slot only coincide when the
  // queue is empty (no head) or full (no push), so the two updates never clash.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pend1_q[i] <= 1'b0;
        pend2_q[i] <= 1'b0;
      end
    end else begin
      if (head_vld) begin
        pend1_q[rd_ptr_q] <= h_p1 & ~iss1;
        pend2_q[rd_ptr_q] <= h_p2 & ~iss2;
      end
      if (push) begin
        bank1_q[wr_ptr_q] <= bus.Src1_Phy_Bank_ID;
        row1_q[wr_ptr_q]  <= bus.Src1_Phy_Row_ID;
        bank2_q[wr_ptr_q] <= bus.Src2_Phy_Bank_ID;
        row2_q[wr_ptr_q]  <= bus.Src2_Phy_Row_ID;
        ocid_q[wr_ptr_q]  <= push_oc;
        pend1_q[wr_ptr_q] <= bus.Src1_Valid;
        pend2_q[wr_ptr_q] <= bus.Src2_Valid;
      end
    end
  end

  assign bus.Ready_ReqFIFO_RAU = (count_q < FULL);
  assign bus.Count             = count_q;
  assign bus.Empty             = (count_q == '0);
  assign bus.RdEn_ReqFIFO_RF   = rd_en_q;
  assign bus.RdRow_ReqFIFO_RF  = rd_row_q;
  assign bus.RdOCID_ReqFIFO_RF = rd_ocid_q;
  assign bus.RdSlot_ReqFIFO_RF = rd_slot_q;

endmodule

// File: tb/tb_rf_req_fifo.sv
module tb_rf_req_fifo;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rf_req_fifo_if #(.AW(AW)) bus ();

  rf_req_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct packed {
    logic [1:0] b1;
    logic [2:0] r1;
    logic       p1;
    logic [1:0] b2;
    logic [2:0] r2;
    logic       p2;
    logic [1:0] oc;
  } ent_t;

  ent_t        mq[$];
  logic [3:0]  exp_en, exp_slot;
  logic [11:0] exp_row;
  logic [7:0]  exp_oc;
  int          checks = 0;
  int          passed = 0;

  function automatic logic [1:0] oc_bin(input logic [3:0] oh);
    if (oh == 4'b0001) return 2'd0;
    if (oh == 4'b0010) return 2'd1;
    if (oh == 4'b0100) return 2'd2;
    if (oh == 4'b1000) return 2'd3;
    return 2'd0;
  endfunction

  // Queue-level reference: advance one clock using the inputs presented now.
  task automatic model_step();
    ent_t h, n;
    bit   i1, i2;
    int   sz;
    sz = mq.size();
    exp_en = '0; exp_row = '0; exp_oc = '0; exp_slot = '0;
    if (rst) begin
      mq.delete();
      return;
    end
    if (sz > 0) begin
      h  = mq[0];
      i1 = h.p1 && !bus.BankBusy_RF_ReqFIFO[h.b1];
      i2 = h.p2 && !bus.BankBusy_RF_ReqFIFO[h.b2] && !(i1 && h.b1 == h.b2);
      if (i1) begin
        exp_en[h.b1] = 1'b1;
        exp_row[3*int'(h.b1) +: 3] = h.r1;
        exp_oc[2*int'(h.b1) +: 2]  = h.oc;
      end
      if (i2) begin
        exp_en[h.b2] = 1'b1;
        exp_row[3*int'(h.b2) +: 3] = h.r2;
        exp_oc[2*int'(h.b2) +: 2]  = h.oc;
        exp_slot[h.b2] = 1'b1;
      end
      h.p1 = h.p1 && !i1;
      h.p2 = h.p2 && !i2;
      if (!h.p1 && !h.p2) void'(mq.pop_front());
      else mq[0] = h;
    end
    if (bus.Valid_RAU_ReqFIFO && sz < DEPTH) begin
      n.b1 = bus.Src1_Phy_Bank_ID; n.r1 = bus.Src1_Phy_Row_ID; n.p1 = bus.Src1_Valid;
      n.b2 = bus.Src2_Phy_Bank_ID; n.r2 = bus.Src2_Phy_Row_ID; n.p2 = bus.Src2_Valid;
      n.oc = oc_bin(bus.OCID_RAU_OC);
      mq.push_back(n);
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s1, input logic [1:0] b1,
                       input logic [2:0] r1, input logic s2, input logic [1:0] b2,
                       input logic [2:0] r2, input logic [3:0] oc);
    bus.Valid_RAU_ReqFIFO = v;
    bus.Src1_Valid = s1; bus.Src1_Phy_Bank_ID = b1; bus.Src1_Phy_Row_ID = r1;
    bus.Src2_Valid = s2; bus.Src2_Phy_Bank_ID = b2; bus.Src2_Phy_Row_ID = r2;
    bus.OCID_RAU_OC = oc;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 2'd0, 3'd0, 4'd0);
  endtask

  task automatic test_reset();
    idle();
    bus.BankBusy_RF_ReqFIFO = 4'b0000;
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    checks++; if (bus.Count !== 3'd0) $display("FAIL reset_count got=%0d exp=0", bus.Count); else passed++;
    checks++; if (bus.Empty !== 1'b1) $display("FAIL reset_empty got=%b exp=1", bus.Empty); else passed++;
    checks++; if (bus.Ready_ReqFIFO_RAU !== 1'b1) $display("FAIL reset_ready got=%b exp=1", bus.Ready_ReqFIFO_RAU); else passed++;
    checks++; if (bus.RdEn_ReqFIFO_RF !== 4'b0) $display("FAIL reset_rden got=%b exp=0000", bus.RdEn_ReqFIFO_RF); else passed++;
    checks++; if ({bus.RdRow_ReqFIFO_RF, bus.RdOCID_ReqFIFO_RF, bus.RdSlot_ReqFIFO_RF} !== 24'd0)
      $display("FAIL reset_fields got=%h/%h/%h exp=0", bus.RdRow_ReqFIFO_RF, bus.RdOCID_ReqFIFO_RF, bus.RdSlot_ReqFIFO_RF);
    else passed++;
  endtask

  task automatic test_single();
    drive(1'b1, 1'b1, 2'd0, 3'd3, 1'b1, 2'd2, 3'd5, 4'b0010);
    cycle();
    idle();
    checks++; if (bus.Count !== 3'd1) $display("FAIL single_count1 got=%0d exp=1", bus.Count); else passed++;
    checks++; if (bus.RdEn_ReqFIFO_RF !== 4'b0) $display("FAIL single_latency got=%b exp=0000", bus.RdEn_ReqFIFO_RF); else passed++;
    cycle();
    checks++; if (bus.RdEn_ReqFIFO_RF !== 4'b0101) $display("FAIL single_rden got=%b exp=0101", bus.RdEn_ReqFIFO_RF); else passed++;
    checks++; if (bus.RdRow_ReqFIFO_RF !== 12'h143) $display("FAIL single_row got=%h exp=143", bus.RdRow_ReqFIFO_RF); else passed++;
    checks++; if (bus.RdOCID_ReqFIFO_RF !== 8'h11) $display("FAIL single_ocid got=%h exp=11", bus.RdOCID_ReqFIFO_RF); else passed++;
    checks++; if (bus.RdSlot_ReqFIFO_RF !== 4'b0100) $display("FAIL single_slot got=%b exp=0100", bus.RdSlot_ReqFIFO_RF); else passed++;
    checks++; if (bus.Count !== 3'd0) $display("FAIL single_count0 got=%0d exp=0", bus.Count); else passed++;
    cycle();
  endtask

  task automatic test_conflict();
    drive(1'b1, 1'b1, 2'd1, 3'd2, 1'b1, 2'd1, 3'd6, 4'b0001);
    cycle();
    idle();
    cycle();
    checks++; if ({bus.RdEn_ReqFIFO_RF, bus.RdRow_ReqFIFO_RF, bus.RdSlot_ReqFIFO_RF} !== {4'b0010, 12'h010, 4'b0000})
      $display("FAIL conflict_a got=%b/%h/%b exp=0010/010/0000", bus.RdEn_ReqFIFO_RF, bus.RdRow_ReqFIFO_RF, bus.RdSlot_ReqFIFO_RF);
    else passed++;
    checks++; if (bus.Count !== 3'd1) $display("FAIL conflict_hold got=%0d exp=1", bus.Count); else passed++;
    cycle();
    checks++; if ({bus.RdEn_ReqFIFO_RF, bus.RdRow_ReqFIFO_RF, bus.RdSlot_ReqFIFO_RF} !== {4'b0010, 12'h030, 4'b0010})
      $display("FAIL conflict_b got=%b/%h/%b exp=0010/030/0010", bus.RdEn_ReqFIFO_RF, bus.RdRow_ReqFIFO_RF, bus.RdSlot_ReqFIFO_RF);
    else passed++;
    checks++; if (bus.Count !== 3'd0) $display("FAIL conflict_pop got=%0d exp=0", bus.Count); else passed++;
    cycle();
    checks++; if (bus.RdEn_ReqFIFO_RF !== 4'b0) $display("FAIL conflict_done got=%b exp=0000", bus.RdEn_ReqFIFO_RF); else passed++;
  endtask

  task automatic test_bank_busy();
    bus.BankBusy_RF_ReqFIFO = 4'b0001;
    drive(1'b1, 1'b1, 2'd0, 3'd1, 1'b0, 2'd0, 3'd0, 4'b0100);
    cycle();
    drive(1'b1, 1'b1, 2'd3, 3'd4, 1'b0, 2'd0, 3'd0, 4'b1000);
    for (int k = 0; k < 3; k++) begin
      cycle();
      idle();
      checks++; if (bus.RdEn_ReqFIFO_RF !== 4'b0) $display("FAIL busy_stall%0d got=%b exp=0000", k, bus.RdEn_ReqFIFO_RF); else passed++;
    end
    bus.BankBusy_RF_ReqFIFO = 4'b0000;
    cycle();
    checks++; if ({bus.RdEn_ReqFIFO_RF, bus.RdRow_ReqFIFO_RF, bus.RdOCID_ReqFIFO_RF} !== {4'b0001, 12'h001, 8'h02})
      $display("FAIL busy_release got=%b/%h/%h exp=0001/001/02", bus.RdEn_ReqFIFO_RF, bus.RdRow_ReqFIFO_RF, bus.RdOCID_ReqFIFO_RF);
    else passed++;
    cycle();
    checks++; if ({bus.RdEn_ReqFIFO_RF, bus.RdRow_ReqFIFO_RF, bus.RdOCID_ReqFIFO_RF} !== {4'b1000, 12'h800, 8'hC0})
      $display("FAIL busy_younger got=%b/%h/%h exp=1000/800/c0", bus.RdEn_ReqFIFO_RF, bus.RdRow_ReqFIFO_RF, bus.RdOCID_ReqFIFO_RF);
    else passed++;
    checks++; if (bus.Count !== 3'd0) $display("FAIL busy_count got=%0d exp=0", bus.Count); else passed++;
  endtask

  task automatic test_fill();
    logic [2:0] row;
    bus.BankBusy_RF_ReqFIFO = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 2'(i % 4), 3'(i + 1), 1'b0, 2'd0, 3'd0, 4'(1 << (i % 4)));
      cycle();
    end
    idle();
    checks++; if (bus.Count !== 3'd4) $display("FAIL fill_count got=%0d exp=4", bus.Count); else passed++;
    checks++; if (bus.Ready_ReqFIFO_RAU !== 1'b0) $display("FAIL fill_ready got=%b exp=0", bus.Ready_ReqFIFO_RAU); else passed++;
    checks++; if (bus.RdEn_ReqFIFO_RF !== 4'b0) $display("FAIL fill_stall got=%b exp=0000", bus.RdEn_ReqFIFO_RF); else passed++;
    bus.BankBusy_RF_ReqFIFO = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      cycle();
      row = bus.RdRow_ReqFIFO_RF[3*i +: 3];
      checks++; if (bus.RdEn_ReqFIFO_RF !== 4'(1 << i) || row !== 3'(i + 1))
        $display("FAIL fill_order%0d got=%b/%0d exp=%b/%0d", i, bus.RdEn_ReqFIFO_RF, row, 4'(1 << i), i + 1);
      else passed++;
    end
    cycle();
    checks++; if (bus.RdEn_ReqFIFO_RF !== 4'b0 || bus.Count !== 3'd0)
      $display("FAIL fill_dropped got=%b/%0d exp=0000/0", bus.RdEn_ReqFIFO_RF, bus.Count);
    else passed++;
    drive(1'b1, 1'b1, 2'd2, 3'd7, 1'b0, 2'd0, 3'd0, 4'b0001);
    cycle();
    idle();
    cycle();
    checks++; if (bus.RdEn_ReqFIFO_RF !== 4'b0100 || bus.RdRow_ReqFIFO_RF !== 12'h1C0)
      $display("FAIL fill_wrap got=%b/%h exp=0100/1c0", bus.RdEn_ReqFIFO_RF, bus.RdRow_ReqFIFO_RF);
    else passed++;
    cycle();
  endtask

  task automatic test_no_src();
    drive(1'b1, 1'b1, 2'd0, 3'd1, 1'b0, 2'd0, 3'd0, 4'b0001);
    cycle();
    drive(1'b1, 1'b0, 2'd3, 3'd7, 1'b0, 2'd3, 3'd7, 4'b0001);
    cycle();
    checks++; if (bus.RdEn_ReqFIFO_RF !== 4'b0001) $display("FAIL nosrc_first got=%b exp=0001", bus.RdEn_ReqFIFO_RF); else passed++;
    drive(1'b1, 1'b1, 2'd1, 3'd2, 1'b0, 2'd0, 3'd0, 4'b0001);
    cycle();
    idle();
    checks++; if (bus.RdEn_ReqFIFO_RF !== 4'b0000) $display("FAIL nosrc_gap got=%b exp=0000", bus.RdEn_ReqFIFO_RF); else passed++;
    cycle();
    checks++; if (bus.RdEn_ReqFIFO_RF !== 4'b0010 || bus.RdRow_ReqFIFO_RF !== 12'h010)
      $display("FAIL nosrc_third got=%b/%h exp=0010/010", bus.RdEn_ReqFIFO_RF, bus.RdRow_ReqFIFO_RF);
    else passed++;
    checks++; if (bus.Count !== 3'd0) $display("FAIL nosrc_count got=%0d exp=0", bus.Count); else passed++;
  endtask

  task automatic test_reset_mid();
    bus.BankBusy_RF_ReqFIFO = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 2'd0, 3'(i + 1), 1'b1, 2'd0, 3'd6, 4'b0010);
      cycle();
    end
    idle();
    bus.BankBusy_RF_ReqFIFO = 4'b0000;
    cycle();
    checks++; if (bus.RdEn_ReqFIFO_RF !== 4'b0001 || bus.Count !== 3'd3)
      $display("FAIL rstmid_pre got=%b/%0d exp=0001/3", bus.RdEn_ReqFIFO_RF, bus.Count);
    else passed++;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    checks++; if (bus.Count !== 3'd0 || bus.Empty !== 1'b1 || bus.RdEn_ReqFIFO_RF !== 4'b0)
      $display("FAIL rstmid_post got=%0d/%b/%b exp=0/1/0000", bus.Count, bus.Empty, bus.RdEn_ReqFIFO_RF);
    else passed++;
    cycle();
    checks++; if (bus.RdEn_ReqFIFO_RF !== 4'b0 || bus.Count !== 3'd0)
      $display("FAIL rstmid_after got=%b/%0d exp=0000/0", bus.RdEn_ReqFIFO_RF, bus.Count);
    else passed++;
  endtask

  task automatic test_random();
    logic [31:0] r;
    int          errs;
    errs = 0;
    for (int n = 0; n < 400; n++) begin
      r = $urandom;
      drive(r[0] | r[1], r[2], r[4:3], r[7:5], r[8], r[10:9], r[13:11], r[17:14]);
      r = $urandom & $urandom;
      bus.BankBusy_RF_ReqFIFO = (n > 380) ? 4'b0000 : r[3:0];
      cycle();
      checks++;
      if (bus.Count !== 3'(mq.size()) || bus.Empty !== (mq.size() == 0) ||
          bus.Ready_ReqFIFO_RAU !== (mq.size() < DEPTH) || bus.RdEn_ReqFIFO_RF !== exp_en ||
          bus.RdRow_ReqFIFO_RF !== exp_row || bus.RdOCID_ReqFIFO_RF !== exp_oc ||
          bus.RdSlot_ReqFIFO_RF !== exp_slot) begin
        if (errs < 10)
          $display("FAIL random_cyc%0d got cnt=%0d en=%b row=%h oc=%h slot=%b exp cnt=%0d en=%b row=%h oc=%h slot=%b",
                   n, bus.Count, bus.RdEn_ReqFIFO_RF, bus.RdRow_ReqFIFO_RF, bus.RdOCID_ReqFIFO_RF,
                   bus.RdSlot_ReqFIFO_RF, mq.size(), exp_en, exp_row, exp_oc, exp_slot);
        errs++;
      end else passed++;
    end
    idle();
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_single();
    test_conflict();
    test_bank_busy();
    test_fill();
    test_no_src();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
